rect_hit_array: RTL

- Pipelined, parametrised rectangle hit tester for the VGA render path. Checks the current scan pixel against NUM_OBJ rectangles (note gems, fret targets, UI boxes) every clock.
- Per pixel: returns whether any enabled rectangle covers it, the lowest-index hit object, and the pixel's offset inside that object for sprite ROM addressing.
- Also latches per-frame "object was drawn" flags for the game logic. Sits between the VGA timing generator and the pixel colour mux.

---
 rtl/rect_hit_array.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rect_hit_array.sv
// Two-stage rectangle hit tester: per-pixel lowest-index hit, offsets and per-frame touch flags.
// Define RECT_HIT_OVERLAP_COUNT_EN to add the hit_count overlap popcount output.
module rect_hit_array #(
    parameter int NUM_OBJ = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int POS_W   = 12,
    parameter int SIZE_W  = 7,
    parameter int IDX_W   = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      pix_valid,
    input  logic [X_W-1:0]            curr_x,
    input  logic [Y_W-1:0]            curr_y,
    input  logic                      frame_start,
    input  logic [NUM_OBJ-1:0]        obj_en,
    input  logic [NUM_OBJ*POS_W-1:0]  obj_x,
    input  logic [NUM_OBJ*POS_W-1:0]  obj_y,
    input  logic [NUM_OBJ*SIZE_W-1:0] obj_w,
    input  logic [NUM_OBJ*SIZE_W-1:0] obj_h,
    output logic                      hit_valid,
    output logic                      hit,
    output logic [IDX_W-1:0]          hit_idx,
    output logic [SIZE_W-1:0]         off_x,
    output logic [SIZE_W-1:0]         off_y,
`ifdef RECT_HIT_OVERLAP_COUNT_EN
    output logic [IDX_W:0]            hit_count,
`endif
    output logic [NUM_OBJ-1:0]        frame_touched
);

    localparam int CW = POS_W + 1;

    logic signed [CW-1:0] px, py;
    logic [NUM_OBJ-1:0]        inside_c;
    logic [NUM_OBJ*SIZE_W-1:0] ox_lo_d, oy_lo_d, ox_lo_q, oy_lo_q;

    assign px = $signed(CW'(curr_x));
    assign py = $signed(CW'(curr_y));

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        logic signed [CW-1:0] x0, y0, x1, y1;
        logic [SIZE_W-1:0]    w, h;
        assign w  = obj_w[g*SIZE_W +: SIZE_W];
        assign h  = obj_h[g*SIZE_W +: SIZE_W];
        assign x0 = CW'($signed(obj_x[g*POS_W +: POS_W]));
        assign y0 = CW'($signed(obj_y[g*POS_W +: POS_W]));
        // Extra bit keeps edge+size from wrapping for objects near the right edge
        assign x1 = x0 + $signed(CW'(w));
        assign y1 = y0 + $signed(CW'(h));
        assign inside_c[g] = obj_en[g] && (w != '0) && (h != '0) &&
                             (px >= x0) && (px < x1) &&
                             (py >= y0) && (py < y1);
        assign ox_lo_d[g*SIZE_W +: SIZE_W] = SIZE_W'(obj_x[g*POS_W +: POS_W]);
        assign oy_lo_d[g*SIZE_W +: SIZE_W] = SIZE_W'(obj_y[g*POS_W +: POS_W]);
    end

    // Stage 1 state
    logic               pv_d, pv_q, fs_d, fs_q;
    logic [X_W-1:0]     x_d, x_q;
    logic [Y_W-1:0]     y_d, y_q;
    logic [NUM_OBJ-1:0] inside_d, inside_q;

    always_comb begin
        pv_d     = pix_valid;
        fs_d     = frame_start;
        x_d      = curr_x;
        y_d      = curr_y;
        inside_d = pix_valid ? inside_c : '0;
    end

    // Stage 2 state
    logic               hit_valid_d, hit_valid_q, hit_d, hit_q;
    logic [IDX_W-1:0]   hit_idx_d, hit_idx_q;
    logic [SIZE_W-1:0]  off_x_d, off_x_q, off_y_d, off_y_q;
    logic [SIZE_W-1:0]  sel_ox, sel_oy;
    logic [NUM_OBJ-1:0] touched_d, touched_q, ftouch_d, ftouch_q;
`ifdef RECT_HIT_OVERLAP_COUNT_EN
    logic [IDX_W:0]     cnt_d, cnt_q;
`endif

    always_comb begin
        hit_idx_d = '0;
        sel_ox    = '0;
        sel_oy    = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (inside_q[i]) begin
                hit_idx_d = IDX_W'(i);
                sel_ox    = ox_lo_q[i*SIZE_W +: SIZE_W];
                sel_oy    = oy_lo_q[i*SIZE_W +: SIZE_W];
            end
        end
        hit_valid_d = pv_q;
        hit_d       = |inside_q;
        off_x_d     = hit_d ? SIZE_W'(x_q) - sel_ox : '0;
        off_y_d     = hit_d ? SIZE_W'(y_q) - sel_oy : '0;
        // The frame_start pixel opens the new frame rather than closing the old one
        touched_d   = touched_q | inside_q;
        ftouch_d    = ftouch_q;
        if (fs_q) begin
            ftouch_d  = touched_q;
            touched_d = inside_q;
        end
`ifdef RECT_HIT_OVERLAP_COUNT_EN
        cnt_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            cnt_d = cnt_d + (IDX_W+1)'(inside_q[i]);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv_q        <= 1'b0;
            fs_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            inside_q    <= '0;
            ox_lo_q     <= '0;
            oy_lo_q     <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            touched_q   <= '0;
            ftouch_q    <= '0;
`ifdef RECT_HIT_OVERLAP_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            pv_q        <= pv_d;
            fs_q        <= fs_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inside_q    <= inside_d;
            ox_lo_q     <= ox_lo_d;
            oy_lo_q     <= oy_lo_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            touched_q   <= touched_d;
            ftouch_q    <= ftouch_d;
`ifdef RECT_HIT_OVERLAP_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign hit_valid     = hit_valid_q;
    assign hit           = hit_q;
    assign hit_idx       = hit_idx_q;
    assign off_x         = off_x_q;
    assign off_y         = off_y_q;
    assign frame_touched = ftouch_q;
`ifdef RECT_HIT_OVERLAP_COUNT_EN
    assign hit_count     = cnt_q;
`endif

endmodule
